// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction-fetch front end. Issues sequential word fetches from an internal
// PC, tags every in-order memory response with the PC that requested it, and
// buffers {inst, pc} pairs in a small queue for a valid/ready decode stage.
// A redirect retargets fetch in one cycle, flushes the queue and marks every
// in-flight response as stale so it is dropped on arrival.
//
// Ports
//   CLK, RSTN               clock (rising edge), asynchronous active-low reset
//   boot_addr               PC loaded while RSTN is low
//   freeze                  blocks new memory requests only
//   redirect_vld/_pc        retarget fetch; redirect_pc[1:0] ignored
//   mem_req/mem_addr        request to instruction memory (word address)
//   mem_gnt                 request accepted when mem_req & mem_gnt
//   mem_rvld/mem_rdata      in-order response, at most one per cycle
//   inst_vld/inst/inst_pc   queue head (inst/inst_pc read 0 when empty)
//   inst_rdy                consumer pops the head when inst_vld & inst_rdy
//   fq_count                occupied queue entries
// ----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int XLEN      = 32,
    parameter int FQ_DEPTH  = 4,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = $clog2(FQ_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [XLEN-1:0]  boot_addr,
    input  logic             freeze,
    input  logic             redirect_vld,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvld,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             inst_vld,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    input  logic             inst_rdy,
    output logic [CNT_W-1:0] fq_count
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    // Pending-PC FIFO pointer keeps at least one bit so MAX_OUTST = 1 still
    // elaborates; wrap is done explicitly against MAX_OUTST-1.
    localparam int PP_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int FQ_W  = $clog2(FQ_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]  fetch_pc_q,  fetch_pc_d;
    logic [OUT_W-1:0] outst_q,     outst_d;
    logic [OUT_W-1:0] discard_q,   discard_d;
    logic [PP_W-1:0]  pp_wr_q,     pp_wr_d;
    logic [PP_W-1:0]  pp_rd_q,     pp_rd_d;
    logic [FQ_W-1:0]  fq_head_q,   fq_head_d;
    logic [FQ_W-1:0]  fq_tail_q,   fq_tail_d;
    logic [CNT_W-1:0] fq_cnt_q,    fq_cnt_d;

    logic [XLEN-1:0]  pp_mem      [MAX_OUTST];
    logic [XLEN-1:0]  fq_inst_mem [FQ_DEPTH];
    logic [XLEN-1:0]  fq_pc_mem   [FQ_DEPTH];

    logic        accept;
    logic        fq_push;
    logic        fq_pop;
    logic        outst_ok;
    logic        credit_ok;
    logic [31:0] occupancy;

    // Low PC bits of a redirect target are forced to zero and never read.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [PP_W-1:0] pp_next(input logic [PP_W-1:0] ptr);
        return (ptr == PP_W'(MAX_OUTST - 1)) ? '0 : ptr + PP_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Issue logic
    // ------------------------------------------------------------------------
    // Queue entries plus in-flight requests never exceed FQ_DEPTH, so every
    // response that is not discarded has a slot waiting for it.
    assign occupancy = 32'(fq_cnt_q) + 32'(outst_q);
    assign credit_ok = occupancy < 32'(FQ_DEPTH);
    assign outst_ok  = outst_q < OUT_W'(MAX_OUTST);

    assign mem_req  = ~freeze & ~redirect_vld & outst_ok & credit_ok;
    assign mem_addr = fetch_pc_q;
    assign accept   = mem_req & mem_gnt;

    // ------------------------------------------------------------------------
    // Queue head
    // ------------------------------------------------------------------------
    assign inst_vld = (fq_cnt_q != '0);
    assign inst     = inst_vld ? fq_inst_mem[fq_head_q] : '0;
    assign inst_pc  = inst_vld ? fq_pc_mem[fq_head_q]   : '0;
    assign fq_count = fq_cnt_q;

    // A redirect flushes the queue, so neither a pop nor a push of a
    // response in that cycle may touch it.
    assign fq_pop  = inst_vld & inst_rdy & ~redirect_vld;
    assign fq_push = mem_rvld & (discard_q == '0) & ~redirect_vld;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        fq_head_d  = fq_head_q;
        fq_tail_d  = fq_tail_q;
        fq_cnt_d   = fq_cnt_q;
        pp_wr_d    = pp_wr_q;
        pp_rd_d    = pp_rd_q;

        // The pending-PC FIFO tracks every request on the bus, stale or not,
        // so it advances independently of redirects.
        if (accept) begin
            pp_wr_d = pp_next(pp_wr_q);
        end
        if (mem_rvld) begin
            pp_rd_d = pp_next(pp_rd_q);
        end
        outst_d = outst_q + OUT_W'(accept) - OUT_W'(mem_rvld);

        if (redirect_vld) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still on the bus after this cycle belongs to the old
            // stream, including responses already marked stale.
            discard_d  = outst_q - OUT_W'(mem_rvld);
            fq_head_d  = '0;
            fq_tail_d  = '0;
            fq_cnt_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (mem_rvld && (discard_q != '0)) begin
                discard_d = discard_q - OUT_W'(1);
            end
            if (fq_push) begin
                fq_tail_d = fq_tail_q + FQ_W'(1);
            end
            if (fq_pop) begin
                fq_head_d = fq_head_q + FQ_W'(1);
            end
            fq_cnt_d = fq_cnt_q + CNT_W'(fq_push) - CNT_W'(fq_pop);
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_pc_q <= boot_addr;
            outst_q    <= '0;
            discard_q  <= '0;
            pp_wr_q    <= '0;
            pp_rd_q    <= '0;
            fq_head_q  <= '0;
            fq_tail_q  <= '0;
            fq_cnt_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            pp_wr_q    <= pp_wr_d;
            pp_rd_q    <= pp_rd_d;
            fq_head_q  <= fq_head_d;
            fq_tail_q  <= fq_tail_d;
            fq_cnt_q   <= fq_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // NOTE: the storage arrays are not reset; the pointers and count above
    // define which entries are valid, and the head outputs are gated to zero
    // when the queue is empty.
    always_ff @(posedge CLK) begin
        if (accept) begin
            pp_mem[pp_wr_q] <= fetch_pc_q;
        end
        if (fq_push) begin
            fq_inst_mem[fq_tail_q] <= mem_rdata;
            fq_pc_mem[fq_tail_q]   <= pp_mem[pp_rd_q];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed phases followed by a randomized phase. A behavioural model built
// from queues (in-flight requests carrying a stale flag, fetch-queue entries)
// predicts every output each cycle; a separate memory model answers the DUT's
// real handshakes after a programmable latency.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch_queue;

    localparam int XLEN      = 32;
    localparam int FQ_DEPTH  = 4;
    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = $clog2(FQ_DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RSTN;
    logic [XLEN-1:0]  boot_addr;
    logic             freeze;
    logic             redirect_vld;
    logic [XLEN-1:0]  redirect_pc;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_gnt;
    logic             mem_rvld;
    logic [XLEN-1:0]  mem_rdata;
    logic             inst_vld;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  inst_pc;
    logic             inst_rdy;
    logic [CNT_W-1:0] fq_count;

    always #5 CLK = ~CLK;

    inst_fetch_queue #(
        .XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .boot_addr(boot_addr), .freeze(freeze),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
        .inst_vld(inst_vld), .inst(inst), .inst_pc(inst_pc),
        .inst_rdy(inst_rdy), .fq_count(fq_count)
    );

    typedef struct { logic [31:0] pc; bit stale; }   infl_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; }   mresp_t;

    infl_t       m_infl[$];   // model: requests in flight, oldest first
    ent_t        m_fq[$];     // model: fetch queue, head first
    mresp_t      mpipe[$];    // memory: accepted requests awaiting response
    logic [31:0] m_pc;
    logic        exp_req;
    logic        act_req;
    logic [31:0] act_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int pops_seen = 0;
    int reqs_seen = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = boot_addr;
        m_infl.delete();
        m_fq.delete();
        mpipe.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_inst_vld"}, 32'(inst_vld), 32'd0);
        check({tag, "_inst"},     inst,          32'd0);
        check({tag, "_inst_pc"},  inst_pc,       32'd0);
        check({tag, "_fq_count"}, 32'(fq_count), 32'd0);
        check({tag, "_mem_addr"}, mem_addr,      boot_addr);
        check({tag, "_mem_req"},  32'(mem_req),  32'(!freeze && !redirect_vld));
    endtask

    task automatic drive_mem();
        if (mpipe.size() > 0 && mpipe[0].due <= cyc + 1) begin
            mem_rvld  = 1'b1;
            mem_rdata = mdata(mpipe[0].addr);
        end else begin
            mem_rvld  = 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance model and memory at
    // the edge, then present the next memory response 1 ns after the edge.
    task automatic cycle();
        bit    push;
        ent_t  e;
        infl_t r;
        @(negedge CLK);
        exp_req = !freeze && !redirect_vld && (m_infl.size() < MAX_OUTST) &&
                  ((m_fq.size() + m_infl.size()) < FQ_DEPTH);
        check("mem_req",  32'(mem_req), 32'(exp_req));
        check("mem_addr", mem_addr, m_pc);
        check("inst_vld", 32'(inst_vld), 32'(m_fq.size() > 0));
        check("inst",     inst,    (m_fq.size() > 0) ? m_fq[0].inst : 32'h0);
        check("inst_pc",  inst_pc, (m_fq.size() > 0) ? m_fq[0].pc   : 32'h0);
        check("fq_count", 32'(fq_count), 32'(m_fq.size()));
        act_req  = mem_req;
        act_addr = mem_addr;
        if (inst_vld && inst_rdy) pops_seen++;
        if (mem_req) reqs_seen++;
        @(posedge CLK);
        push = 1'b0;
        if (mem_rvld) begin
            check("rvld_legal", 32'(m_infl.size() > 0), 32'd1);
            if (m_infl.size() > 0) begin
                r = m_infl.pop_front();
                if (!r.stale) begin
                    push   = 1'b1;
                    e.inst = mdata(r.pc);
                    e.pc   = r.pc;
                end
            end
        end
        if (redirect_vld) begin
            m_fq.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_fq.size() > 0 && inst_rdy) void'(m_fq.pop_front());
            if (push) m_fq.push_back(e);
            if (exp_req && mem_gnt) begin
                m_infl.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        if (mem_rvld && mpipe.size() > 0) void'(mpipe.pop_front());
        if (act_req && mem_gnt) mpipe.push_back('{addr: act_addr, due: cyc + lat});
        #1;
        drive_mem();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0; boot_addr = 32'h0000_1000; freeze = 1'b0;
        redirect_vld = 1'b0; redirect_pc = '0; mem_gnt = 1'b1;
        mem_rvld = 1'b0; mem_rdata = '0; inst_rdy = 1'b1;
        model_reset();
        #12;
        check_reset("boot");
        @(posedge CLK);
        #2 RSTN = 1'b1;

        // Sequential fetch, L = 1, consumer always ready.
        repeat (6) cycle();
        pops_seen = 0;
        repeat (8) cycle();
        check("throughput", 32'(pops_seen), 32'd8);

        // Consumer stalled: queue fills to FQ_DEPTH and requests stop.
        inst_rdy = 1'b0;
        repeat (12) cycle();
        check("full_count", 32'(fq_count), 32'(FQ_DEPTH));
        check("full_req",   32'(mem_req),  32'd0);
        inst_rdy = 1'b1;
        repeat (10) cycle();

        // L = 3: redirect while two requests are in flight.
        lat = 3;
        for (int i = 0; i < 20 && m_infl.size() != 2; i++) cycle();
        redirect_vld = 1'b1; redirect_pc = 32'h0000_2003; inst_rdy = 1'b0;
        cycle();
        redirect_vld = 1'b0;
        check("redir_flush", 32'(fq_count), 32'd0);
        for (int i = 0; i < 30 && fq_count != 2; i++) cycle();
        check("redir_head_pc",   inst_pc, 32'h0000_2000);
        check("redir_head_inst", inst,    mdata(32'h0000_2000));
        inst_rdy = 1'b1;
        cycle();
        check("redir_next_pc", inst_pc, 32'h0000_2004);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        repeat (6) cycle();
        for (int i = 0; i < 10 && !(mem_rvld && inst_vld); i++) cycle();
        redirect_vld = 1'b1; redirect_pc = 32'h0000_3000;
        cycle();
        redirect_vld = 1'b0;
        check("rvld_redir_vld",   32'(inst_vld), 32'd0);
        check("rvld_redir_count", 32'(fq_count), 32'd0);
        repeat (10) cycle();

        // freeze mid-stream.
        freeze = 1'b1;
        reqs_seen = 0;
        repeat (5) cycle();
        check("freeze_no_req", 32'(reqs_seen), 32'd0);
        freeze = 1'b0;
        repeat (8) cycle();

        // PC wrap-around.
        redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_vld = 1'b0;
        check("wrap_start", mem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && mem_addr == 32'hFFFF_FFFC; i++) cycle();
        check("wrap_next", mem_addr, 32'h0000_0000);
        repeat (6) cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            mem_gnt      = ($urandom_range(0, 3) != 0);
            inst_rdy     = ($urandom_range(0, 3) != 0);
            freeze       = ($urandom_range(0, 9) == 0);
            redirect_vld = ($urandom_range(0, 19) == 0);
            redirect_pc  = $urandom;
            cycle();
        end

        // Reset pulsed mid-burst.
        freeze = 1'b0; redirect_vld = 1'b0; mem_gnt = 1'b1; inst_rdy = 1'b0; lat = 2;
        repeat (8) cycle();
        #3 RSTN = 1'b0;
        mem_rvld = 1'b0;
        #1;
        check_reset("pulse");
        model_reset();
        @(posedge CLK);
        #2 RSTN = 1'b1;
        inst_rdy = 1'b1;
        repeat (12) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
